// File: rtl/ddr3_rd_arbiter.sv
// ddr3_rd_arbiter: two-requester burst read arbiter for the shared DDR3 Avalon read port,
// with beat credit limit, starvation guard and in-order return steering.
`default_nettype none

module ddr3_rd_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 128,
    parameter int BURST_MAX    = 4,
    parameter int MAX_BEATS    = 16,
    parameter int TAG_DEPTH    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [2:0]        r0_size,
    output logic              r0_grant,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [2:0]        r1_size,
    output logic              r1_grant,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              ddr3_avl_ready,
    output logic              ddr3_avl_read_req,
    output logic              ddr3_avl_burstbegin,
    output logic [ADDR_W-1:0] ddr3_avl_addr,
    output logic [2:0]        ddr3_avl_size,
    input  logic              ddr3_avl_read_data_valid,
    input  logic [DATA_W-1:0] ddr3_avl_read_data,
    output logic              err
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [2:0]        BURST_MAX_L = 3'(BURST_MAX);
    localparam logic [BEAT_W:0]   MAX_BEATS_L = (BEAT_W + 1)'(MAX_BEATS);
    localparam logic [CNT_W-1:0]  TAG_FULL_L  = CNT_W'(TAG_DEPTH);
    localparam logic [STV_W-1:0]  STARVE_L    = STV_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(TAG_DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [BEAT_W-1:0] beats;
    logic [STV_W-1:0]  starve;
    logic              sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_size;
    logic              first;

    logic              tag_id  [TAG_DEPTH];
    logic [2:0]        tag_rem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  tag_cnt;

    logic r0_legal, r1_legal, r0_elig, r1_elig, r0_bad, r1_bad, force_r1, tag_full;
    logic pick, pick_id, accept, ret, pop, head_id;
    logic [2:0] head_rem;
    logic [BEAT_W:0] r0_need, r1_need;

    assign r0_legal = (r0_size != 3'd0) && (r0_size <= BURST_MAX_L);
    assign r1_legal = (r1_size != 3'd0) && (r1_size <= BURST_MAX_L);
    assign r0_need  = {1'b0, beats} + (BEAT_W + 1)'(r0_size);
    assign r1_need  = {1'b0, beats} + (BEAT_W + 1)'(r1_size);
    assign tag_full = (tag_cnt == TAG_FULL_L);
    assign r0_elig  = r0_req && r0_legal && (r0_need <= MAX_BEATS_L) && !tag_full;
    assign r1_elig  = r1_req && r1_legal && (r1_need <= MAX_BEATS_L) && !tag_full;
    assign r0_bad   = r0_req && !r0_legal;
    assign r1_bad   = r1_req && !r1_legal;
    assign force_r1 = (starve == STARVE_L) && r1_req;

    assign head_id  = tag_id[rd_ptr];
    assign head_rem = tag_rem[rd_ptr];
    assign ret      = ddr3_avl_read_data_valid && (tag_cnt != '0);
    assign pop      = ret && (head_rem == 3'd1);

    always_comb begin
        state_nxt           = state;
        pick                = 1'b0;
        pick_id             = 1'b0;
        accept              = 1'b0;
        r0_grant            = 1'b0;
        r1_grant            = 1'b0;
        ddr3_avl_read_req   = 1'b0;
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_addr       = '0;
        ddr3_avl_size       = 3'd0;
        case (state)
            IDLE: begin
                // Illegal sizes are acknowledged and dropped without touching arbitration.
                r0_grant = r0_bad;
                r1_grant = r1_bad;
                if (force_r1) begin
                    if (r1_elig) begin
                        pick    = 1'b1;
                        pick_id = 1'b1;
                    end
                end else if (r0_elig) begin
                    pick    = 1'b1;
                    pick_id = 1'b0;
                end else if (r1_elig) begin
                    pick    = 1'b1;
                    pick_id = 1'b1;
                end
                if (pick) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ddr3_avl_read_req   = 1'b1;
                ddr3_avl_burstbegin = first;
                ddr3_avl_addr       = sel_addr;
                ddr3_avl_size       = sel_size;
                if (ddr3_avl_ready) begin
                    accept    = 1'b1;
                    r0_grant  = !sel_id;
                    r1_grant  = sel_id;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel_id   <= 1'b0;
            sel_addr <= '0;
            sel_size <= 3'd0;
            first    <= 1'b0;
            starve   <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pick) begin
                sel_id   <= pick_id;
                sel_addr <= pick_id ? r1_addr : r0_addr;
                sel_size <= pick_id ? r1_size : r0_size;
                first    <= 1'b1;
            end else if (state == ISSUE) begin
                first <= 1'b0;
            end
            if (!r1_req || r1_grant) begin
                starve <= '0;
            end else if (r0_grant && (starve != STARVE_L)) begin
                starve <= starve + 1'b1;
            end
            if (((state == IDLE) && (r0_bad || r1_bad)) ||
                (ddr3_avl_read_data_valid && (tag_cnt == '0))) begin
                err <= 1'b1;
            end
        end
    end

    // Head entry's remaining-beat field counts down in place; the entry pops on its last beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_id[wr_ptr]  <= sel_id;
            tag_rem[wr_ptr] <= sel_size;
        end
        if (ret && !pop) begin
            tag_rem[rd_ptr] <= head_rem - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_cnt   <= '0;
            beats     <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            rdata     <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            beats     <= beats + (accept ? BEAT_W'(sel_size) : '0) - BEAT_W'(ret);
            r0_rvalid <= ret && !head_id;
            r1_rvalid <= ret && head_id;
            if (ret) begin
                rdata <= ddr3_avl_read_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_rd_arbiter.sv
// Directed self-checking bench for ddr3_rd_arbiter.
`default_nettype none

module tb_ddr3_rd_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         r0_req = 1'b0, r1_req = 1'b0;
    logic [25:0]  r0_addr = '0, r1_addr = '0;
    logic [2:0]   r0_size = '0, r1_size = '0;
    logic         r0_grant, r1_grant, r0_rvalid, r1_rvalid;
    logic [127:0] rdata;
    logic         ddr3_avl_ready = 1'b1;
    logic         ddr3_avl_read_req, ddr3_avl_burstbegin;
    logic [25:0]  ddr3_avl_addr;
    logic [2:0]   ddr3_avl_size;
    logic         ddr3_avl_read_data_valid = 1'b0;
    logic [127:0] ddr3_avl_read_data = '0;
    logic         err;

    int total = 0;
    int bad   = 0;

    ddr3_rd_arbiter dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .r0_req                   (r0_req),
        .r0_addr                  (r0_addr),
        .r0_size                  (r0_size),
        .r0_grant                 (r0_grant),
        .r0_rvalid                (r0_rvalid),
        .r1_req                   (r1_req),
        .r1_addr                  (r1_addr),
        .r1_size                  (r1_size),
        .r1_grant                 (r1_grant),
        .r1_rvalid                (r1_rvalid),
        .rdata                    (rdata),
        .ddr3_avl_ready           (ddr3_avl_ready),
        .ddr3_avl_read_req        (ddr3_avl_read_req),
        .ddr3_avl_burstbegin      (ddr3_avl_burstbegin),
        .ddr3_avl_addr            (ddr3_avl_addr),
        .ddr3_avl_size            (ddr3_avl_size),
        .ddr3_avl_read_data_valid (ddr3_avl_read_data_valid),
        .ddr3_avl_read_data       (ddr3_avl_read_data),
        .err                      (err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        cyc();
        reset_n = 1'b0;
        r0_req = 1'b0;
        r1_req = 1'b0;
        ddr3_avl_read_data_valid = 1'b0;
        ddr3_avl_ready = 1'b1;
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({r0_grant, r1_grant, r0_rvalid, r1_rvalid, ddr3_avl_read_req, ddr3_avl_burstbegin, err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {r0_grant, r1_grant, r0_rvalid, r1_rvalid, ddr3_avl_read_req, ddr3_avl_burstbegin, err});
        end
        total++;
        if ({ddr3_avl_addr, ddr3_avl_size, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_buses got addr=%h size=%h rdata=%h exp=0", ddr3_avl_addr, ddr3_avl_size, rdata);
        end
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        cyc();
        r0_req = 1'b1; r0_addr = 26'h100; r0_size = 3'd4;
        @(negedge clk);
        total++;
        if ({ddr3_avl_read_req, r0_grant} !== 2'b00) begin
            bad++; $display("FAIL single_idle got req/grant=%b exp=00", {ddr3_avl_read_req, r0_grant});
        end
        cyc();
        @(negedge clk);
        total++;
        if ({ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant, r1_grant, ddr3_avl_addr, ddr3_avl_size}
            !== {4'b1110, 26'h100, 3'd4}) begin
            bad++;
            $display("FAIL single_issue got req=%b bb=%b g0=%b g1=%b addr=%h size=%0d exp 1 1 1 0 100 4",
                     ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant, r1_grant, ddr3_avl_addr, ddr3_avl_size);
        end
        cyc();
        r0_req = 1'b0;
        @(negedge clk);
        total++;
        if ({ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant} !== 3'b000 || dut.beats !== 5'd4) begin
            bad++;
            $display("FAIL single_after got req=%b bb=%b g0=%b beats=%0d exp 0 0 0 4",
                     ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant, dut.beats);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            ddr3_avl_read_data_valid = (i < 4);
            ddr3_avl_read_data = 128'hA0 + 128'(i);
            @(negedge clk);
            total++;
            if (r0_rvalid !== (i > 0) || r1_rvalid !== 1'b0 ||
                (i > 0 && rdata !== 128'hA0 + 128'(i - 1))) begin
                bad++;
                $display("FAIL single_beat%0d got rv0=%b rv1=%b rdata=%h exp rv0=%b rv1=0 rdata=%h",
                         i, r0_rvalid, r1_rvalid, rdata, (i > 0), 128'hA0 + 128'(i - 1));
            end
        end
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (r0_rvalid !== 1'b0 || rdata !== 128'hA3 || dut.beats !== 5'd0) begin
            bad++;
            $display("FAIL single_done got rv0=%b rdata=%h beats=%0d exp 0 a3 0", r0_rvalid, rdata, dut.beats);
        end
    endtask

    task automatic test_ready_stall();
        cyc();
        r0_req = 1'b1; r0_addr = 26'h2AA; r0_size = 3'd2; ddr3_avl_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            total++;
            if (ddr3_avl_read_req !== 1'b1 || ddr3_avl_addr !== 26'h2AA || ddr3_avl_size !== 3'd2 ||
                ddr3_avl_burstbegin !== (k == 0) || r0_grant !== 1'b0) begin
                bad++;
                $display("FAIL stall_cyc%0d got req=%b addr=%h size=%0d bb=%b g0=%b exp 1 2aa 2 %b 0",
                         k, ddr3_avl_read_req, ddr3_avl_addr, ddr3_avl_size, ddr3_avl_burstbegin, r0_grant, (k == 0));
            end
        end
        cyc();
        ddr3_avl_ready = 1'b1;
        @(negedge clk);
        total++;
        if (r0_grant !== 1'b1 || ddr3_avl_burstbegin !== 1'b0 || ddr3_avl_addr !== 26'h2AA) begin
            bad++;
            $display("FAIL stall_accept got g0=%b bb=%b addr=%h exp 1 0 2aa", r0_grant, ddr3_avl_burstbegin, ddr3_avl_addr);
        end
        cyc();
        r0_req = 1'b0;
        ddr3_avl_read_data_valid = 1'b1;
        cyc();
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (r0_rvalid !== 1'b1 || dut.beats !== 5'd0) begin
            bad++; $display("FAIL stall_return got rv0=%b beats=%0d exp 1 0", r0_rvalid, dut.beats);
        end
    endtask

    task automatic test_starvation();
        int n = 0;
        logic pending = 1'b0;
        cyc();
        r0_req = 1'b1; r0_addr = 26'h10; r0_size = 3'd1;
        r1_req = 1'b1; r1_addr = 26'h20; r1_size = 3'd1;
        for (int t = 0; t < 60 && n < 10; t++) begin
            cyc();
            ddr3_avl_read_data_valid = pending;
            pending = 1'b0;
            @(negedge clk);
            if (r0_grant || r1_grant) begin
                total++;
                if (r1_grant !== ((n % 5) == 4) || r0_grant !== ((n % 5) != 4)) begin
                    bad++;
                    $display("FAIL starve_grant%0d got g0=%b g1=%b exp g1=%b", n, r0_grant, r1_grant, ((n % 5) == 4));
                end
                n++;
                pending = 1'b1;
            end
        end
        total++;
        if (n !== 10) begin
            bad++; $display("FAIL starve_timeout got grants=%0d exp 10", n);
        end
        cyc();
        r0_req = 1'b0; r1_req = 1'b0;
        ddr3_avl_read_data_valid = pending;
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dut.beats !== 5'd0) begin
            bad++; $display("FAIL starve_beats got=%0d exp 0", dut.beats);
        end
    endtask

    task automatic test_credit();
        logic got;
        logic blocked;
        int   cnt;
        for (int c = 0; c < 4; c++) begin
            cyc();
            r0_req = 1'b1; r0_addr = 26'h400 + 26'(c * 4); r0_size = 3'd4;
            got = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                @(negedge clk);
                if (r0_grant) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++; $display("FAIL credit_grant%0d got no grant exp grant", c);
            end
            cyc();
            r0_req = 1'b0;
        end
        @(negedge clk);
        total++;
        if (dut.beats !== 5'd16) begin
            bad++; $display("FAIL credit_full got beats=%0d exp 16", dut.beats);
        end
        cyc();
        r0_req = 1'b1; r0_addr = 26'h500; r0_size = 3'd4;
        blocked = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (ddr3_avl_read_req) blocked = 1'b0;
        end
        cyc();
        ddr3_avl_read_data_valid = 1'b1;
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (ddr3_avl_read_req) blocked = 1'b0;
        end
        total++;
        if (!blocked || dut.beats !== 5'd15) begin
            bad++; $display("FAIL credit_blocked got blocked=%b beats=%0d exp 1 15", blocked, dut.beats);
        end
        cyc();
        ddr3_avl_read_data_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 6 && !got; t++) begin
            @(negedge clk);
            if (r0_grant) got = 1'b1;
        end
        total++;
        if (!got || ddr3_avl_addr !== 26'h500) begin
            bad++; $display("FAIL credit_release got grant=%b addr=%h exp 1 500", got, ddr3_avl_addr);
        end
        cyc();
        r0_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 18; i++) begin
            cyc();
            ddr3_avl_read_data_valid = (i < 16);
            @(negedge clk);
            if (r0_rvalid) cnt++;
        end
        total++;
        if (cnt !== 16 || dut.beats !== 5'd0) begin
            bad++; $display("FAIL credit_drain got beats_seen=%0d beats=%0d exp 16 0", cnt, dut.beats);
        end
    endtask

    task automatic test_interleave();
        logic [4:0] exp_rv1;
        exp_rv1 = 5'b11100;
        cyc();
        r0_req = 1'b1; r0_addr = 26'h200; r0_size = 3'd2;
        cyc();
        @(negedge clk);
        total++;
        if (r0_grant !== 1'b1) begin
            bad++; $display("FAIL ilv_g0 got=%b exp 1", r0_grant);
        end
        cyc();
        r0_req = 1'b0;
        r1_req = 1'b1; r1_addr = 26'h300; r1_size = 3'd3;
        cyc();
        ddr3_avl_read_data_valid = 1'b1;
        ddr3_avl_read_data = 128'hB0;
        @(negedge clk);
        total++;
        if (r1_grant !== 1'b1 || ddr3_avl_addr !== 26'h300 || ddr3_avl_size !== 3'd3) begin
            bad++; $display("FAIL ilv_g1 got g1=%b addr=%h size=%0d exp 1 300 3", r1_grant, ddr3_avl_addr, ddr3_avl_size);
        end
        for (int i = 1; i < 6; i++) begin
            cyc();
            r1_req = 1'b0;
            ddr3_avl_read_data_valid = (i < 5);
            ddr3_avl_read_data = 128'hB0 + 128'(i);
            @(negedge clk);
            if (i == 1) begin
                total++;
                if (dut.beats !== 5'd4) begin
                    bad++; $display("FAIL ilv_concurrent got beats=%0d exp 4", dut.beats);
                end
            end
            total++;
            if (r1_rvalid !== exp_rv1[i - 1] || r0_rvalid !== !exp_rv1[i - 1] || rdata !== 128'hB0 + 128'(i - 1)) begin
                bad++;
                $display("FAIL ilv_beat%0d got rv0=%b rv1=%b rdata=%h exp rv1=%b rdata=%h",
                         i, r0_rvalid, r1_rvalid, rdata, exp_rv1[i - 1], 128'hB0 + 128'(i - 1));
            end
        end
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dut.beats !== 5'd0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
            bad++; $display("FAIL ilv_done got beats=%0d rv0=%b rv1=%b exp 0 0 0", dut.beats, r0_rvalid, r1_rvalid);
        end
    endtask

    task automatic test_errors();
        cyc();
        r1_req = 1'b1; r1_addr = 26'h77; r1_size = 3'd0;
        @(negedge clk);
        total++;
        if (r1_grant !== 1'b1 || ddr3_avl_read_req !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL err_size0 got g1=%b req=%b err=%b exp 1 0 0", r1_grant, ddr3_avl_read_req, err);
        end
        cyc();
        r1_req = 1'b0;
        @(negedge clk);
        total++;
        if (err !== 1'b1 || ddr3_avl_read_req !== 1'b0) begin
            bad++; $display("FAIL err_size0_flag got err=%b req=%b exp 1 0", err, ddr3_avl_read_req);
        end
        pulse_reset();
        ddr3_avl_read_data_valid = 1'b1;
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_cleared got=%b exp 0", err);
        end
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || err !== 1'b1) begin
            bad++; $display("FAIL err_empty got rv0=%b rv1=%b err=%b exp 0 0 1", r0_rvalid, r1_rvalid, err);
        end
        pulse_reset();
        r0_req = 1'b1; r0_addr = 26'h55; r0_size = 3'd5;
        r1_req = 1'b1; r1_addr = 26'h66; r1_size = 3'd2;
        @(negedge clk);
        total++;
        if (r0_grant !== 1'b1 || r1_grant !== 1'b0 || ddr3_avl_read_req !== 1'b0) begin
            bad++; $display("FAIL err_big_grant got g0=%b g1=%b req=%b exp 1 0 0", r0_grant, r1_grant, ddr3_avl_read_req);
        end
        cyc();
        r0_req = 1'b0;
        @(negedge clk);
        total++;
        if (r1_grant !== 1'b1 || ddr3_avl_addr !== 26'h66 || err !== 1'b1) begin
            bad++; $display("FAIL err_other_arb got g1=%b addr=%h err=%b exp 1 66 1", r1_grant, ddr3_avl_addr, err);
        end
        cyc();
        r1_req = 1'b0;
        ddr3_avl_read_data_valid = 1'b1;
        cyc();
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (r1_rvalid !== 1'b1 || dut.beats !== 5'd0) begin
            bad++; $display("FAIL err_other_ret got rv1=%b beats=%0d exp 1 0", r1_rvalid, dut.beats);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        r0_req = 1'b1; r0_addr = 26'h123; r0_size = 3'd2; ddr3_avl_ready = 1'b0;
        cyc();
        @(negedge clk);
        total++;
        if (ddr3_avl_read_req !== 1'b1) begin
            bad++; $display("FAIL rstmid_issue got req=%b exp 1", ddr3_avl_read_req);
        end
        cyc();
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if ({ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant, r1_grant, err} !== 5'b0 || ddr3_avl_addr !== 26'h0) begin
            bad++;
            $display("FAIL rstmid_clear got req=%b bb=%b g0=%b g1=%b err=%b addr=%h exp all 0",
                     ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant, r1_grant, err, ddr3_avl_addr);
        end
        cyc();
        ddr3_avl_ready = 1'b1;
        cyc();
        reset_n = 1'b1;
        cyc();
        @(negedge clk);
        total++;
        if (ddr3_avl_read_req !== 1'b1 || ddr3_avl_burstbegin !== 1'b1 || r0_grant !== 1'b1 || ddr3_avl_addr !== 26'h123) begin
            bad++;
            $display("FAIL rstmid_resume got req=%b bb=%b g0=%b addr=%h exp 1 1 1 123",
                     ddr3_avl_read_req, ddr3_avl_burstbegin, r0_grant, ddr3_avl_addr);
        end
        cyc();
        r0_req = 1'b0;
        ddr3_avl_read_data_valid = 1'b1;
        cyc();
        cyc();
        ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (r0_rvalid !== 1'b1 || dut.beats !== 5'd0 || err !== 1'b0) begin
            bad++; $display("FAIL rstmid_return got rv0=%b beats=%0d err=%b exp 1 0 0", r0_rvalid, dut.beats, err);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_ready_stall();
        test_starvation();
        test_credit();
        test_interleave();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ddr3_rd_arbiter.md
Name: ddr3_rd_arbiter

Overview:
- Shares the single DDR3 Avalon-MM read port between two framebuffer read requesters.
  - Requester 0: VGA line fetch, high priority.
  - Requester 1: secondary reader (overlay/blitter/CSR readback).
- Arbitrates and issues burst read commands, tracks outstanding beats with a credit limit, and steers returned read data back to the requester that issued the command, in issue order.
- Sits between the requester engines and the DDR3 controller local interface, all in the clk domain.

Parameters:
- ADDR_W, 26, DDR3 Avalon word address width.
- DATA_W, 128, read data width.
- BURST_MAX, 4, largest legal burst size in beats (legal range 1..BURST_MAX).
- MAX_BEATS, 16, maximum beats outstanding (issued, not yet returned).
- TAG_DEPTH, 8, depth of the in-order tag FIFO (max outstanding commands).
- STARVE_LIMIT, 4, consecutive requester-0 grants while requester 1 waits before requester 1 is forced to win.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 read request; held with addr/size until r0_grant.
- r0_addr  in  ADDR_W  requester 0 burst start address.
- r0_size  in  3  requester 0 burst length in beats.
- r0_grant  out  1  one-cycle pulse: command accepted.
- r0_rvalid  out  1  read beat valid for requester 0.
- r1_req / r1_addr / r1_size / r1_grant / r1_rvalid  as above, requester 1.
- rdata  out  DATA_W  shared read data, qualified by r0_rvalid / r1_rvalid.
- ddr3_avl_ready  in  1  controller accepts command when high.
- ddr3_avl_read_req  out  1  read command valid.
- ddr3_avl_burstbegin  out  1  first cycle of a command presentation.
- ddr3_avl_addr  out  ADDR_W  command address.
- ddr3_avl_size  out  3  command burst size.
- ddr3_avl_read_data_valid  in  1  return beat valid.
- ddr3_avl_read_data  in  DATA_W  return beat data.
- err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; tag FIFO empty; starve counter 0.
- State machine, IDLE:
  - Eligible requester = req high, size legal, beats + size <= MAX_BEATS, and tag FIFO not full.
  - Winner selection: requester 0 wins unless the starve counter equals STARVE_LIMIT and r1_req is high, in which case requester 1 wins.
  - On selection: latch winner id, addr and size; next cycle enter ISSUE.
- State machine, ISSUE:
  - ddr3_avl_read_req = 1 and addr/size driven from the latch.
  - ddr3_avl_burstbegin = 1 only in the first ISSUE cycle.
  - Command fields are held stable while ddr3_avl_ready = 0.
  - Accept cycle (read_req & ready):
    - Combinational grant pulse to the winner.
    - Push {id, size} to the tag FIFO.
    - beats += size.
    - Return to IDLE.
  - Maximum command rate: one command every 2 cycles.
- Starve counter:
  - Increments on a requester-0 grant while r1_req = 1.
  - Clears on any requester-1 grant, or when r1_req = 0.
- Illegal size (0 or > BURST_MAX):
  - Granted from IDLE for one cycle with no DDR command issued.
  - err is set.
  - Other requester's arbitration is unaffected.
- Return path:
  - Each read_data_valid beat is registered, giving 1-cycle latency to rdata/rN_rvalid.
  - The beat is routed by the id at the head of the tag FIFO.
  - beats decrements by 1 per beat.
  - The head size is decremented per beat; the tag is popped on its last beat.
- Simultaneous accept and return in one cycle: beats = beats + size − 1; FIFO push and pop both occur.
- read_data_valid with the tag FIFO empty: beat dropped, no rvalid asserted, err set.
- Only one rvalid is high in any cycle; rdata holds its value when no beat is valid.
- Reset mid-burst:
  - All state clears immediately, with no completion of pending grants.
  - Stale beats returning after reset hit the empty-FIFO error rule.

Test Plan:
- Single read: r0 req addr 0x100 size 4, ready=1 → burstbegin 1 cycle, r0_grant 2 cycles after req, 4 returned beats appear on r0_rvalid, each 1 cycle after the corresponding data_valid; beats returns to 0.
- Contention and starvation: r0 and r1 both held continuously → 4 r0 grants, then 1 r1 grant, repeating; ready low for 3 cycles → addr/size stable, burstbegin high only in the first cycle.
- Credit limit: 4 r0 size-4 commands with no returns → fifth command blocked (beats = 16); one beat returned → still blocked; 4 beats returned → fifth command issues.
- Interleaved return: r0 size 2 then r1 size 3 → beats 1–2 on r0_rvalid, beats 3–5 on r1_rvalid; a return coinciding with an accept keeps the beat count exact.
- Errors: r1 size 0 → r1_grant pulses, no read_req, err = 1; a data_valid beat with no outstanding command → no rvalid, err = 1.
- Reset during ISSUE with ready low → all outputs 0 next cycle, and the next request after reset release proceeds normally.
